// File: rtl/router_rx_fifo.sv
// Per-port router RX buffer: link skid + PT merge into an FWFT FIFO; head visible the cycle after the write edge.
// D_BP/PT_BP are registered threshold flags; optional drop counter enabled by ROUTER_RX_DROPCNT_EN.
module router_rx_fifo #(
   parameter int DataWidth = 64,
   parameter int Depth     = 8,
   parameter int BpSlack   = 2
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic [DataWidth-1:0]         D,
   input  logic                         D_VALID,
   output logic                         D_BP,
   input  logic [DataWidth-1:0]         PT,
   input  logic                         PT_VALID,
   output logic                         PT_BP,
   output logic [DataWidth-1:0]         Q,
   output logic                         Q_VALID,
   input  logic                         Q_BP,
   input  logic                         COLLISION,
   output logic [$clog2(Depth+1)-1:0]   LEVEL,
   output logic                         OVERFLOW,
   output logic [15:0]                  DROP_CNT
);

   localparam int AW = $clog2(Depth);
   localparam int LW = $clog2(Depth+1);
   localparam int SW = LW + 1;
   localparam logic [LW-1:0] DEPTH_L   = LW'(Depth);
   localparam logic [SW-1:0] BP_THRESH = SW'(Depth - BpSlack);

   localparam logic [0:0] SKID_EMPTY = 1'b0;
   localparam logic [0:0] SKID_FULL  = 1'b1;

   logic [DataWidth-1:0] mem_q [Depth];
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [LW-1:0]        level_q, level_d;
   logic [0:0]           skid_q, skid_d;
   logic [DataWidth-1:0] skid_dat_q, skid_dat_d;
   logic                 d_bp_q, d_bp_d;
   logic                 pt_bp_q, pt_bp_d;
   logic                 overflow_q, overflow_d;

   logic                 pop, wr_ok, wr_pt, wr_skid, wr_d, wr;
   logic                 d_pending, load_skid, drop;
   logic [DataWidth-1:0] wr_dat;
   logic [SW-1:0]        occ_next;

   assign Q_VALID  = (level_q != '0);
   assign Q        = mem_q[rd_ptr_q];
   assign LEVEL    = level_q;
   assign D_BP     = d_bp_q;
   assign PT_BP    = pt_bp_q;
   assign OVERFLOW = overflow_q;

   always_comb begin
      pop     = Q_VALID & ~Q_BP & ~COLLISION;
      wr_ok   = (level_q != DEPTH_L) | pop;
      wr_pt   = PT_VALID & wr_ok;
      wr_skid = ~PT_VALID & (skid_q == SKID_FULL) & wr_ok;
      wr_d    = ~PT_VALID & (skid_q == SKID_EMPTY) & D_VALID & wr_ok;
      wr      = wr_pt | wr_skid | wr_d;

      wr_dat = D;
      if (wr_pt) begin
         wr_dat = PT;
      end else if (wr_skid) begin
         wr_dat = skid_dat_q;
      end

      // A displaced link word may take the skid slot in the same cycle the skid drains.
      d_pending = D_VALID & ~wr_d;
      load_skid = d_pending & ((skid_q == SKID_EMPTY) | wr_skid);
      drop      = d_pending & ~load_skid;

      skid_d     = skid_q;
      skid_dat_d = skid_dat_q;
      if (load_skid) begin
         skid_d     = SKID_FULL;
         skid_dat_d = D;
      end else if (wr_skid) begin
         skid_d = SKID_EMPTY;
      end

      rd_ptr_d   = rd_ptr_q + AW'(pop);
      wr_ptr_d   = wr_ptr_q + AW'(wr);
      level_d    = level_q + LW'(wr) - LW'(pop);
      occ_next   = {1'b0, level_d} + SW'(skid_d == SKID_FULL);
      d_bp_d     = (occ_next >= BP_THRESH);
      pt_bp_d    = (level_d == DEPTH_L);
      overflow_d = overflow_q | drop;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         level_q    <= '0;
         skid_q     <= SKID_EMPTY;
         skid_dat_q <= '0;
         d_bp_q     <= 1'b0;
         pt_bp_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         level_q    <= level_d;
         skid_q     <= skid_d;
         skid_dat_q <= skid_dat_d;
         d_bp_q     <= d_bp_d;
         pt_bp_q    <= pt_bp_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is left unreset so it can map onto a RAM; the pointers define validity.
   always_ff @(posedge CLK) begin
      if (wr && !RST) begin
         mem_q[wr_ptr_q] <= wr_dat;
      end
   end

`ifdef ROUTER_RX_DROPCNT_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign DROP_CNT = drop_cnt_q;
`else
   assign DROP_CNT = 16'h0;
`endif

endmodule

// File: tb/tb_router_rx_fifo.sv
// Directed vectors for router_rx_fifo (Depth=8, BpSlack=2); outputs checked 1 time unit after each rising edge.
module tb_router_rx_fifo;

`ifdef ROUTER_RX_DROPCNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic        CLK;
   logic        RST;
   logic [63:0] D;
   logic        D_VALID;
   logic        D_BP;
   logic [63:0] PT;
   logic        PT_VALID;
   logic        PT_BP;
   logic [63:0] Q;
   logic        Q_VALID;
   logic        Q_BP;
   logic        COLLISION;
   logic [3:0]  LEVEL;
   logic        OVERFLOW;
   logic [15:0] DROP_CNT;

   router_rx_fifo #(.DataWidth(64), .Depth(8), .BpSlack(2)) dut (
      .CLK(CLK), .RST(RST),
      .D(D), .D_VALID(D_VALID), .D_BP(D_BP),
      .PT(PT), .PT_VALID(PT_VALID), .PT_BP(PT_BP),
      .Q(Q), .Q_VALID(Q_VALID), .Q_BP(Q_BP), .COLLISION(COLLISION),
      .LEVEL(LEVEL), .OVERFLOW(OVERFLOW), .DROP_CNT(DROP_CNT)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   typedef struct {
      logic        rst, dv;
      logic [63:0] d;
      logic        pv;
      logic [63:0] pt;
      logic        qbp, coll;
      logic        eqv;
      logic [63:0] eq;
      logic [3:0]  elvl;
      logic        edbp, eptbp, eovf;
      logic [15:0] edrop;
   } vec_t;

   vec_t vecs[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   task automatic add(input int rst, input int dv, input logic [63:0] d, input int pv,
                      input logic [63:0] pt, input int qbp, input int coll, input int eqv,
                      input logic [63:0] eq, input int elvl, input int edbp, input int eptbp,
                      input int eovf, input int ndrop);
      vec_t v;
      v.rst = rst[0]; v.dv = dv[0]; v.d = d; v.pv = pv[0]; v.pt = pt;
      v.qbp = qbp[0]; v.coll = coll[0]; v.eqv = eqv[0]; v.eq = eq;
      v.elvl = elvl[3:0]; v.edbp = edbp[0]; v.eptbp = eptbp[0]; v.eovf = eovf[0];
      v.edrop = CNT_EN ? ndrop[15:0] : 16'h0;
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic dv, input logic [63:0] d, input logic pv,
                        input logic [63:0] pt, input logic qbp, input logic coll);
      RST = rst; D_VALID = dv; D = d; PT_VALID = pv; PT = pt; Q_BP = qbp; COLLISION = coll;
      @(posedge CLK);
      #1;
   endtask

   logic [63:0] tail_h [7];

   initial begin
      RST = 1'b1; D = '0; D_VALID = 1'b0; PT = '0; PT_VALID = 1'b0; Q_BP = 1'b0; COLLISION = 1'b0;
      tail_h = '{64'h4, 64'h5, 64'h6, 64'h7, 64'h8, 64'hBB, 64'h9};

      // reset then idle
      add(1,0,0,0,0,0,0, 0,0,0,0,0,0,0);
      add(1,0,0,0,0,0,0, 0,0,0,0,0,0,0);
      add(0,0,0,0,0,1,0, 0,0,0,0,0,0,0);
      // fill 1..8 with head blocked, then drain in order
      for (int k = 1; k <= 8; k++) add(0,1,k,0,0,1,0, 1,1,k, int'(k >= 6), int'(k == 8), 0,0);
      add(0,0,0,0,0,1,0, 1,1,8,1,1,0,0);
      for (int k = 1; k <= 8; k++) add(0,0,0,0,0,0,0, int'(k < 8), k+1, 8-k, int'(8-k >= 6), 0,0,0);
      // PT/D collision: PT first, link words follow via the skid
      add(0,1,1,1,'hA,1,0, 1,'hA,1,0,0,0,0);
      add(0,1,2,0,0,1,0,   1,'hA,2,0,0,0,0);
      add(0,0,0,0,0,1,0,   1,'hA,3,0,0,0,0);
      add(0,0,0,0,0,0,0,   1,1,2,0,0,0,0);
      add(0,0,0,0,0,0,0,   1,2,1,0,0,0,0);
      add(0,0,0,0,0,0,0,   0,0,0,0,0,0,0);
      // COLLISION holds the head
      add(0,1,5,0,0,0,0, 1,5,1,0,0,0,0);
      for (int k = 0; k < 3; k++) add(0,0,0,0,0,0,1, 1,5,1,0,0,0,0);
      add(0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
      // overflow: full FIFO + full skid, three more link words dropped
      for (int k = 1; k <= 8; k++) add(0,1,k,0,0,1,0, 1,1,k, int'(k >= 6), int'(k == 8), 0,0);
      add(0,1,9,0,0,1,0, 1,1,8,1,1,0,0);
      for (int j = 1; j <= 3; j++) add(0,1,9+j,0,0,1,0, 1,1,8,1,1,1,j);
      // push+pop at full: PT becomes tail, skid word follows it
      add(0,0,0,1,'hBB,0,0, 1,2,8,1,1,1,3);
      add(0,0,0,0,0,0,0,    1,3,8,1,1,1,3);
      for (int k = 0; k < 7; k++) add(0,0,0,0,0,0,0, 1,tail_h[k],7-k,int'(7-k >= 6),0,1,3);
      add(0,0,0,0,0,0,0, 0,0,0,0,0,1,3);
      // reset mid-operation discards FIFO and skid, clears OVERFLOW
      add(0,1,'hB,1,'hA,1,0, 1,'hA,1,0,0,1,3);
      add(1,0,0,0,0,0,0, 0,0,0,0,0,0,0);
      add(0,0,0,0,0,0,0, 0,0,0,0,0,0,0);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].dv, vecs[i].d, vecs[i].pv, vecs[i].pt, vecs[i].qbp, vecs[i].coll);
         n_vec++;
         chk($sformatf("v%0d q_valid", i), 64'(Q_VALID), 64'(vecs[i].eqv));
         if (vecs[i].eqv) chk($sformatf("v%0d q", i), Q, vecs[i].eq);
         chk($sformatf("v%0d level", i),    64'(LEVEL),    64'(vecs[i].elvl));
         chk($sformatf("v%0d d_bp", i),     64'(D_BP),     64'(vecs[i].edbp));
         chk($sformatf("v%0d pt_bp", i),    64'(PT_BP),    64'(vecs[i].eptbp));
         chk($sformatf("v%0d overflow", i), 64'(OVERFLOW), 64'(vecs[i].eovf));
         chk($sformatf("v%0d drop_cnt", i), 64'(DROP_CNT), 64'(vecs[i].edrop));
      end

      // PT offered while full is held off, then accepted on the cycle the head pops
      for (int k = 1; k <= 8; k++) drive(0, 1, 64'(k), 0, 0, 1, 0);
      for (int k = 0; k < 2; k++) begin
         drive(0, 0, 0, 1, 64'h77, 1, 0);
         n_vec++;
         chk("pt_hold level", 64'(LEVEL), 64'd8);
         chk("pt_hold pt_bp", 64'(PT_BP), 64'd1);
         chk("pt_hold q", Q, 64'd1);
      end
      drive(0, 0, 0, 1, 64'h77, 0, 0);
      n_vec++;
      chk("pt_accept level", 64'(LEVEL), 64'd8);
      chk("pt_accept q", Q, 64'd2);
      for (int k = 0; k < 7; k++) begin
         drive(0, 0, 0, 0, 0, 0, 0);
         n_vec++;
         chk($sformatf("pt_drain%0d level", k), 64'(LEVEL), 64'(7 - k));
         chk($sformatf("pt_drain%0d q", k), Q, (k < 6) ? 64'(3 + k) : 64'h77);
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      n_vec++;
      chk("pt_end q_valid", 64'(Q_VALID), 64'd0);
      chk("pt_end overflow", 64'(OVERFLOW), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
